// File: rtl/ether_tx_if.sv
// Payload dibit stream between packet assembly and the RMII transmit framer.
interface ether_tx_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiil;
    logic       axiir;

    modport master (
        output axiiv,
        output axiid,
        output axiil,
        input  axiir
    );

    modport slave (
        input  axiiv,
        input  axiid,
        input  axiil,
        output axiir
    );
endinterface

// File: rtl/ether_tx.sv
// RMII transmit framer: preamble, SFD, payload, CRC-32 FCS, then inter-frame gap.
module ether_tx #(
    parameter int IFG_DIBITS = 48,
    parameter bit FCS_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ether_tx_if.slave  bus,
    output logic       txen,
    output logic [1:0] txd,
    output logic       underrun
);

    localparam int CW = (IFG_DIBITS > 32) ? $clog2(IFG_DIBITS) : 5;
    localparam logic [CW-1:0] PRE_LAST = CW'(30);
    localparam logic [CW-1:0] FCS_DONE = CW'(16);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_DIBITS - 2);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        FCS,
        IFG
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   crc;
    logic [31:0]   fcs_sh;
    logic          rdy;

    assign bus.axiir = rdy;
    assign fcs_sh    = ~crc >> {cnt[3:0], 1'b0};

    function automatic logic [31:0] crc_step(
        input logic [31:0] c,
        input logic [1:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            crc      <= '1;
            txen     <= 1'b0;
            txd      <= 2'b00;
            rdy      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.axiiv) begin
                        state <= PRE;
                        cnt   <= '0;
                        txen  <= 1'b1;
                        txd   <= 2'b01;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= SFD;
                        txd   <= 2'b11;
                        rdy   <= 1'b1;
                        crc   <= '1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SFD, DATA: begin
                    if (!bus.axiiv) begin
                        state    <= IFG;
                        cnt      <= '0;
                        txen     <= 1'b0;
                        txd      <= 2'b00;
                        rdy      <= 1'b0;
                        underrun <= 1'b1;
                    end else begin
                        txd <= bus.axiid;
                        crc <= crc_step(crc, bus.axiid);
                        if (bus.axiil) begin
                            // Without FCS the counter starts exhausted, so only
                            // the last payload dibit is held before the gap.
                            state <= FCS;
                            rdy   <= 1'b0;
                            cnt   <= FCS_EN ? '0 : FCS_DONE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                FCS: begin
                    if (cnt == FCS_DONE) begin
                        state <= IFG;
                        cnt   <= '0;
                        txen  <= 1'b0;
                        txd   <= 2'b00;
                    end else begin
                        txd <= fcs_sh[1:0];
                        cnt <= cnt + 1'b1;
                    end
                end
                IFG: begin
                    // The IDLE cycle that follows completes the gap.
                    if (cnt == IFG_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ether_tx.sv
// Directed bench for ether_tx: reset, framing, CRC, back-to-back, underrun, async reset.
module tb_ether_tx;

    logic       clk;
    logic       rst;
    logic       txen;
    logic [1:0] txd;
    logic       underrun;

    ether_tx_if bus ();

    ether_tx #(
        .IFG_DIBITS(48),
        .FCS_EN    (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .txen    (txen),
        .txd     (txd),
        .underrun(underrun)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [1:0] src [0:1][0:63];

    logic [1:0] cap [$];
    int         len_q [$];
    int         gap_q [$];
    int         rise_q [$];
    int         cyc = 0;
    int         hi = 0;
    int         lo = 0;
    int         und_n = 0;
    int         idle_bad = 0;
    logic       und_txen = 1'b1;
    logic       prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (txen) begin
            cap.push_back(txd);
            if (!prev) begin
                gap_q.push_back(lo);
                rise_q.push_back(cyc);
            end
            hi++;
            lo = 0;
        end else begin
            if (prev) len_q.push_back(hi);
            hi = 0;
            lo++;
            if (txd !== 2'b00) idle_bad++;
        end
        if (underrun) begin
            und_n++;
            und_txen = txen;
        end
        prev = txen;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear();
        cap.delete();
        len_q.delete();
        gap_q.delete();
        rise_q.delete();
        und_n = 0;
        und_txen = 1'b1;
    endtask

    function automatic logic [1:0] got(input int idx);
        if (idx < cap.size()) return cap[idx];
        return 2'bxx;
    endfunction

    function automatic int qget(input int q [$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    function automatic logic [31:0] fcs_model(input int sel, input int n);
        logic [31:0] c;
        logic        b;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 2; j++) begin
                b = src[sel][k][j];
                if (c[0] ^ b) c = (c >> 1) ^ 32'hEDB8_8320;
                else          c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic stream(input int sel, input int n, input int drop,
                          output bit aborted);
        int  i;
        bit  x;
        i = 0;
        aborted = 1'b0;
        for (int k = 0; k < 600 && i < n && !aborted; k++) begin
            bus.axiiv = 1'b1;
            bus.axiid = src[sel][i];
            bus.axiil = (i == n - 1);
            if (i == drop && bus.axiir) begin
                bus.axiiv = 1'b0;
                aborted = 1'b1;
            end
            x = bus.axiiv & bus.axiir;
            step();
            if (x) i++;
        end
        chk("stream_done", 32'((i == n) || aborted), 32'd1);
    endtask

    task automatic wait_low(input string tag);
        for (int k = 0; k < 300 && txen; k++) step();
        chk(tag, 32'(txen), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int sel,
                               input int n, input int off);
        int          bad;
        logic [31:0] f;
        bad = 0;
        for (int k = 0; k < 31; k++) if (got(off + k) !== 2'b01) bad++;
        chk({tag, "_pre"}, bad, 0);
        chk({tag, "_sfd"}, 32'(got(off + 31)), 32'd3);
        bad = 0;
        for (int k = 0; k < n; k++) if (got(off + 32 + k) !== src[sel][k]) bad++;
        chk({tag, "_pay"}, bad, 0);
        f = '0;
        for (int k = 0; k < 16; k++) f[2*k +: 2] = got(off + 32 + n + k);
        chk({tag, "_fcs"}, f, fcs_model(sel, n));
    endtask

    bit          ab;
    int          rel;
    logic [7:0]  byt;
    logic [31:0] fw;

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        bus.axiiv = 1'b1;
        bus.axiid = 2'b01;
        bus.axiil = 1'b0;

        // Reset held with a pending request: outputs stay quiet.
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_txen", 32'(txen), 32'd0);
            chk("rst_txd", 32'(txd), 32'd0);
            chk("rst_rdy", 32'(bus.axiir), 32'd0);
        end

        // Four-dibit frame straight out of reset.
        src[0][0] = 2'b01; src[0][1] = 2'b10;
        src[0][2] = 2'b11; src[0][3] = 2'b00;
        clear();
        rel = cyc;
        rst = 1'b1;
        stream(0, 4, -1, ab);
        bus.axiiv = 1'b0;
        wait_low("pre_end");
        chk("pre_lat", qget(rise_q, 0) - rel, 1);
        chk("pre_len", qget(len_q, 0), 52);
        check_frame("pre", 0, 4, 0);
        repeat (60) step();

        // "123456789" gives the well-known check value.
        for (int b = 0; b < 9; b++) begin
            byt = 8'h31 + 8'(b);
            for (int j = 0; j < 4; j++) src[0][4*b + j] = byt[2*j +: 2];
        end
        clear();
        stream(0, 36, -1, ab);
        bus.axiiv = 1'b0;
        wait_low("crc_end");
        chk("crc_len", qget(len_q, 0), 84);
        fw = '0;
        for (int k = 0; k < 16; k++) fw[2*k +: 2] = got(68 + k);
        chk("crc_word", fw, 32'hCBF4_3926);
        chk("crc_d0", 32'(got(68)), 32'd2);
        chk("crc_d1", 32'(got(69)), 32'd1);
        chk("crc_d2", 32'(got(70)), 32'd2);
        chk("crc_d3", 32'(got(71)), 32'd0);
        check_frame("crc", 0, 36, 0);
        repeat (60) step();

        // Back-to-back frames with valid held high.
        for (int k = 0; k < 8; k++) src[0][k] = 2'(k * 3 + 1);
        for (int k = 0; k < 6; k++) src[1][k] = 2'(k ^ 2);
        clear();
        stream(0, 8, -1, ab);
        stream(1, 6, -1, ab);
        bus.axiiv = 1'b0;
        wait_low("b2b_end");
        chk("b2b_len_a", qget(len_q, 0), 56);
        chk("b2b_len_b", qget(len_q, 1), 54);
        chk("b2b_gap", qget(gap_q, 1), 48);
        check_frame("b2b_a", 0, 8, 0);
        check_frame("b2b_b", 1, 6, 56);
        repeat (60) step();

        // Underrun mid-payload, then a fresh frame right away.
        for (int k = 0; k < 10; k++) src[0][k] = 2'(k);
        src[1][0] = 2'b11; src[1][1] = 2'b00;
        src[1][2] = 2'b10; src[1][3] = 2'b01;
        clear();
        stream(0, 10, 5, ab);
        chk("und_abort", 32'(ab), 32'd1);
        stream(1, 4, -1, ab);
        bus.axiiv = 1'b0;
        wait_low("und_end");
        chk("und_pulses", und_n, 1);
        chk("und_txen", 32'(und_txen), 32'd0);
        chk("und_len", qget(len_q, 0), 37);
        chk("und_gap", qget(gap_q, 1), 48);
        chk("und_next_len", qget(len_q, 1), 52);
        check_frame("und_next", 1, 4, 37);
        repeat (60) step();

        // Asynchronous reset in the middle of the payload.
        bus.axiiv = 1'b1;
        bus.axiid = 2'b10;
        bus.axiil = 1'b0;
        repeat (40) step();
        chk("arst_pre", 32'(txen), 32'd1);
        #5;
        rst = 1'b0;
        #1;
        chk("arst_txen", 32'(txen), 32'd0);
        chk("arst_txd", 32'(txd), 32'd0);
        chk("arst_rdy", 32'(bus.axiir), 32'd0);
        step();
        step();
        src[0][0] = 2'b10; src[0][1] = 2'b10;
        src[0][2] = 2'b01; src[0][3] = 2'b11;
        clear();
        rel = cyc;
        rst = 1'b1;
        stream(0, 4, -1, ab);
        bus.axiiv = 1'b0;
        wait_low("arst_end");
        chk("arst_lat", qget(rise_q, 0) - rel, 1);
        chk("arst_len", qget(len_q, 0), 52);
        check_frame("arst", 0, 4, 0);

        chk("idle_txd", idle_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ether_tx.md
# ether_tx

RMII transmit framer, the transmit-side counterpart of the `ether` receiver. It accepts a frame as a ready/valid stream of dibits (LSB-first within each byte) and drives the RMII `txen`/`txd` pins. Each frame goes out as preamble, SFD, payload and a computed CRC-32 FCS, followed by an enforced inter-frame gap. It sits between the packet-assembly logic and the PHY and runs on the 50 MHz RMII reference clock.

## Interface
- `IFG_DIBITS`, default 48: idle dibit-times after the last FCS dibit (96 bit times).
- `FCS_EN`, default 1: when 1, append the 16-dibit FCS; when 0, skip the FCS state.
- `clk`  in  1  50 MHz RMII reference clock; all logic is on the rising edge.
- `rst`  in  1  Asynchronous, active-low reset. Assertion at 0 takes effect immediately; release is synchronous to `clk`.
- `axiiv`  in  1  Payload dibit valid.
- `axiid`  in  2  Payload dibit. Bit 0 is the earlier bit on the wire.
- `axiil`  in  1  Marks the last payload dibit of the frame. Qualified by `axiiv & axiir`.
- `axiir`  out  1  Ready. A beat transfers when `axiiv & axiir` is 1 at a rising edge.
- `txen`  out  1  RMII TX_EN. Registered.
- `txd`  out  2  RMII TXD. Registered. Held at 00 whenever `txen` is 0.
- `underrun`  out  1  One-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PRE, SFD, DATA, FCS, IFG.
- **IDLE:**
  - `axiir`=0.
  - When `axiiv`=1, go to PRE. The presented beat is not consumed.
- **PRE:**
  - Output 31 dibits of 01 (bytes 0x55).
  - A 5-bit counter is used; go to SFD after the 31st dibit.
- **SFD:**
  - Output one dibit of 11, which completes byte 0xD5.
  - `axiir`=1 during this cycle, so the first payload beat is accepted while the SFD is on the wire.
- **DATA:**
  - `axiir`=1 until the beat carrying `axiil` is accepted.
  - Each accepted beat appears on `txd` the following cycle with `txen`=1.
  - Accepting the `axiil` beat deasserts `axiir` at that same edge.
  - The state then moves to FCS, or to IFG when `FCS_EN`=0.
- **Underrun:**
  - Condition: `axiir`=1 and `axiiv`=0 at any edge in SFD or DATA.
  - Response: abort the frame. Next cycle `txen`=0, `txd`=00, `underrun`=1 for one cycle, and the state goes to IFG.
  - A partial frame is never completed and no FCS is sent.
- **CRC:**
  - Ethernet CRC-32, reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at the SFD cycle.
  - Updated with 2 bits per accepted payload beat, `axiid[0]` first.
  - The preamble and SFD are excluded from the CRC.
- **FCS:**
  - fcs = ~crc. Output 16 dibits; dibit k is fcs[2k+1:2k], k = 0..15.
- **IFG:**
  - `txen`=0, `txd`=00, `axiir`=0 for `IFG_DIBITS` cycles, then go to IDLE.
  - `axiiv` is ignored throughout IFG.
- **Padding:** none. Upstream must supply at least 60 payload bytes (240 dibits) for a standards-compliant frame; shorter frames are transmitted as given.

## Timing
- Reset values: `txen`=0, `txd`=00, `axiir`=0, `underrun`=0, state IDLE, CRC register 0xFFFFFFFF.
- Reset mid-frame: `txen` drops asynchronously and nothing further is sent. After release, the block starts in IDLE with no IFG.
- Start latency: with `axiiv`=1 in IDLE at edge t, `txen`=1 and `txd`=01 from edge t+1.
- Frame length: `txen` is high for exactly 32 + N + 16 contiguous cycles for N payload dibits (32 + N when `FCS_EN`=0), with no gaps.
- Payload latency: a beat accepted at edge t is on `txd` from t+1 to t+2.
- Back-to-back frames: the next frame's preamble starts no earlier than `IFG_DIBITS`+1 cycles after the last `txen`=1 cycle.
- `axiil` with N=1: the `axiil` beat is accepted in the SFD cycle, then FCS follows immediately.

## Test plan
- **Reset:** hold `rst`=0 with `axiiv`=1 → `txen`=0, `txd`=00, `axiir`=0 throughout; after release, preamble begins 1 cycle later.
- **Preamble:** frame of 4 dibits → `txd` sequence is 31×01, then 11, then the 4 payload dibits, then 16 FCS dibits; `txen` high for 52 cycles.
- **CRC check:** payload ASCII "123456789" (36 dibits) → FCS 0xCBF43926. First FCS dibits are 10, 01, 10, 00 (byte 0x26); `txen` high for 84 cycles.
- **Back-to-back:** two frames with `axiiv` held high → `txen` low for exactly 48 cycles between frames; no beat lost or duplicated (check against a scoreboard).
- **Underrun:** drop `axiiv` for one cycle mid-DATA → `txen` low the next cycle, `underrun` pulse of width 1, 48-cycle IFG, then a clean new frame.
- **Async reset:** assert `rst`=0 mid-DATA, between edges → `txen` falls without waiting for a clock edge; after release, an IDLE-to-frame start works with 1-cycle latency.
